// File: rtl/servile_wb_byte_loader_pkg.sv
// servile_wb_byte_loader_pkg
//   Shared definitions for the boot-stream Wishbone loader:
//   - state_t     : loader FSM states (IDLE, FILL, BUS, DONE)
//   - lane sizing : a word is four 8-bit byte lanes, little-endian
//   - lanes_differ: byte-lane compare restricted to enabled lanes
package servile_wb_byte_loader_pkg;

    localparam int lane_count = 4;
    localparam int lane_bits  = 8;
    localparam int word_bits  = lane_count * lane_bits;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        BUS  = 2'd2,
        DONE = 2'd3
    } state_t;

    // True when any byte lane selected by mask differs between a and b.
    // Lanes outside the mask never contribute, so partial words verify cleanly.
    function automatic logic lanes_differ(input logic [word_bits-1:0]  a,
                                          input logic [word_bits-1:0]  b,
                                          input logic [lane_count-1:0] mask);
        logic diff;
        diff = 1'b0;
        for (int i = 0; i < lane_count; i++) begin
            if (mask[i] && (a[i*lane_bits +: lane_bits] != b[i*lane_bits +: lane_bits]))
                diff = 1'b1;
        end
        return diff;
    endfunction

endpackage

// File: rtl/servile_wb_byte_loader_if.sv
// servile_wb_byte_loader_if
//   Bundles the byte-stream side and the Wishbone side of the loader.
//   Signal names keep the loader's point of view (i_* into the loader,
//   o_* out of it).
//   master : loader view (drives o_*, samples i_*)
//   slave  : environment view (stream source + Wishbone responder)
//   Stream : i_start, i_verify, i_base_adr, i_data, i_valid, i_last, o_ready
//   Status : o_busy, o_done, o_err, o_words
//   Bus    : o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_stb, i_wb_rdt, i_wb_ack
interface servile_wb_byte_loader_if #(parameter int aw = 8);

    logic          i_start;
    logic          i_verify;
    logic [aw-3:0] i_base_adr;
    logic [7:0]    i_data;
    logic          i_valid;
    logic          i_last;
    logic          o_ready;
    logic          o_busy;
    logic          o_done;
    logic          o_err;
    logic [aw-2:0] o_words;
    logic [aw-3:0] o_wb_adr;
    logic [31:0]   o_wb_dat;
    logic [3:0]    o_wb_sel;
    logic          o_wb_we;
    logic          o_wb_stb;
    logic [31:0]   i_wb_rdt;
    logic          i_wb_ack;

    modport master (
        input  i_start, i_verify, i_base_adr, i_data, i_valid, i_last,
        input  i_wb_rdt, i_wb_ack,
        output o_ready, o_busy, o_done, o_err, o_words,
        output o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_stb
    );

    modport slave (
        output i_start, i_verify, i_base_adr, i_data, i_valid, i_last,
        output i_wb_rdt, i_wb_ack,
        input  o_ready, o_busy, o_done, o_err, o_words,
        input  o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_stb
    );

endinterface

// File: rtl/servile_byte_packer.sv
// servile_byte_packer
//   Assembles up to four stream bytes into a little-endian 32-bit word.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : drop the partial word (lane, word, mask, last -> 0)
//   accept   : a stream byte is taken this cycle
//   data     : the byte; lands in lane 'lane' (lane 0 = bits 7:0)
//   last_in  : the byte is the final one of the image
//   word     : assembled word, unfilled lanes read as zero
//   mask     : one bit per filled lane
//   full     : this accept completes a word (fourth lane or final byte)
//   last     : the most recently accepted byte was the final one
module servile_byte_packer
    import servile_wb_byte_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  accept,
    input  logic [lane_bits-1:0]  data,
    input  logic                  last_in,
    output logic [word_bits-1:0]  word,
    output logic [lane_count-1:0] mask,
    output logic                  full,
    output logic                  last
);

    logic [1:0] lane;

    assign full = accept && ((lane == 2'd3) || last_in);

    // NOTE: the word register is reset too, so the bus never shows stale bytes
    // from a previous image in lanes a partial word does not fill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane <= 2'd0;
            word <= '0;
            mask <= '0;
            last <= 1'b0;
        end else if (clear) begin
            lane <= 2'd0;
            word <= '0;
            mask <= '0;
            last <= 1'b0;
        end else if (accept) begin
            // NOTE: non-blocking assignments so every register here samples
            // the pre-edge lane index, whatever order the statements are in.
            word[{lane, 3'b000} +: lane_bits] <= data;
            mask[lane]                        <= 1'b1;
            lane                              <= lane + 2'd1;
            last                              <= last_in;
        end
    end

endmodule

// File: rtl/servile_wb_byte_loader.sv
// servile_wb_byte_loader
//   Boot-stream to Wishbone initiator for the shared-SRAM port of the servile
//   arbiter. Write mode packs four bytes per word and writes consecutive words
//   from a base address; verify mode reads the same words back and flags any
//   mismatch in the filled byte lanes.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   bus          : stream handshake, status and Wishbone signals (master view)
//   Parameter aw : byte address width of the SRAM (word address is aw-2 bits)
module servile_wb_byte_loader
    import servile_wb_byte_loader_pkg::*;
#(
    parameter int aw = 8
)
(
    input  logic                     i_clk,
    input  logic                     i_rst,
    servile_wb_byte_loader_if.master bus
);

    localparam logic [aw-3:0] adr_one   = 1;
    localparam logic [aw-2:0] words_one = 1;

    state_t state, state_next;

    logic          verify_q;
    logic [aw-3:0] adr_q;
    logic          err_q;
    logic [aw-2:0] words_q;

    logic                  start;
    logic                  accept;
    logic                  ack;
    logic [word_bits-1:0]  word;
    logic [lane_count-1:0] mask;
    logic                  full;
    logic                  last;

    logic                  ready_c;
    logic                  stb_c;
    logic                  we_c;
    logic [word_bits-1:0]  dat_c;
    logic [lane_count-1:0] sel_c;
    logic                  done_c;
    logic                  busy_c;

    // Handshakes only count in the state that expects them; a stray start
    // or ack elsewhere is ignored.
    assign start  = (state == IDLE) && bus.i_start;
    assign accept = (state == FILL) && bus.i_valid;
    assign ack    = (state == BUS)  && bus.i_wb_ack;

    servile_byte_packer u_packer (
        .clk     (i_clk),
        .rst     (i_rst),
        .clear   (start || ack),
        .accept  (accept),
        .data    (bus.i_data),
        .last_in (bus.i_last),
        .word    (word),
        .mask    (mask),
        .full    (full),
        .last    (last)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Wishbone outputs decode from the state register alone, so the async
    // reset drops the strobe immediately and the bus stays stable while the
    // arbiter stalls the ack.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned, which would infer a latch.
        state_next = state;
        ready_c    = 1'b0;
        stb_c      = 1'b0;
        we_c       = 1'b0;
        dat_c      = '0;
        sel_c      = '0;
        done_c     = 1'b0;
        busy_c     = 1'b1;
        unique case (state)
            IDLE: begin
                busy_c = 1'b0;
                if (bus.i_start) state_next = FILL;
            end
            FILL: begin
                ready_c = 1'b1;
                if (full) state_next = BUS;
            end
            BUS: begin
                stb_c = 1'b1;
                we_c  = !verify_q;
                dat_c = word;
                sel_c = mask;
                if (bus.i_wb_ack) state_next = last ? DONE : FILL;
            end
            DONE: begin
                done_c     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            verify_q <= 1'b0;
            adr_q    <= '0;
            err_q    <= 1'b0;
            words_q  <= '0;
        end else begin
            if (start) begin
                verify_q <= bus.i_verify;
                adr_q    <= bus.i_base_adr;
                err_q    <= 1'b0;
                words_q  <= '0;
            end
            if (ack) begin
                if (verify_q && lanes_differ(bus.i_wb_rdt, word, mask))
                    err_q <= 1'b1;
                // Address and count both wrap naturally at their widths.
                adr_q   <= adr_q + adr_one;
                words_q <= words_q + words_one;
            end
        end
    end

    assign bus.o_ready  = ready_c;
    assign bus.o_busy   = busy_c;
    assign bus.o_done   = done_c;
    assign bus.o_err    = err_q;
    assign bus.o_words  = words_q;
    assign bus.o_wb_adr = adr_q;
    assign bus.o_wb_dat = dat_c;
    assign bus.o_wb_sel = sel_c;
    assign bus.o_wb_we  = we_c;
    assign bus.o_wb_stb = stb_c;

endmodule

// File: tb/tb_servile_wb_byte_loader.sv
// tb_servile_wb_byte_loader
//   Self-checking bench for servile_wb_byte_loader (aw = 8). A small model
//   turns each byte image into the list of Wishbone transfers it must produce;
//   a per-cycle monitor acts as the SRAM responder and compares every strobed
//   cycle against that list. Literal expectations pin the model.
module tb_servile_wb_byte_loader;

    typedef struct {
        logic [5:0]  adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
    } xfer_t;

    logic clk = 1'b0;
    logic rst;

    servile_wb_byte_loader_if #(.aw(8)) bus ();

    servile_wb_byte_loader #(.aw(8)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    xfer_t       exp_q[$];
    logic [31:0] mem [64];
    logic [7:0]  img [16];
    int          ack_delay = 1;
    bit          mon_en = 1'b1;
    int          wait_cnt = 0;
    bit          acked_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor + SRAM responder: all sampling and driving at the falling edge.
    always @(negedge clk) begin
        if (!mon_en) begin
            wait_cnt   = 0;
            acked_prev = 1'b0;
        end else if (rst) begin
            bus.i_wb_ack = 1'b0;
            wait_cnt     = 0;
            acked_prev   = 1'b0;
        end else begin
            if (acked_prev) check("stb_low_after_ack", bus.o_wb_stb, 1'b0);
            acked_prev = 1'b0;
            if (bus.o_wb_stb) begin
                check("ready_low_in_bus", bus.o_ready, 1'b0);
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe_queue", exp_q.size(), 1);
                    bus.i_wb_ack = 1'b0;
                end else begin
                    check("wb_adr", bus.o_wb_adr, exp_q[0].adr);
                    check("wb_dat", bus.o_wb_dat, exp_q[0].dat);
                    check("wb_sel", bus.o_wb_sel, exp_q[0].sel);
                    check("wb_we",  bus.o_wb_we,  exp_q[0].we);
                    if (wait_cnt >= ack_delay) begin
                        bus.i_wb_rdt = mem[bus.o_wb_adr];
                        if (bus.o_wb_we) mem[bus.o_wb_adr] = bus.o_wb_dat;
                        bus.i_wb_ack = 1'b1;
                        void'(exp_q.pop_front());
                        wait_cnt   = 0;
                        acked_prev = 1'b1;
                    end else begin
                        bus.i_wb_ack = 1'b0;
                        wait_cnt++;
                    end
                end
            end else begin
                bus.i_wb_ack = 1'b0;
                wait_cnt     = 0;
            end
        end
    end

    // Model: the transfers and final status an image must produce.
    task automatic build_expect(input logic [5:0] base, input bit verify, input int n,
                                output bit exp_err, output int nwords);
        xfer_t       x;
        logic [31:0] lane_mask;
        exp_err = 1'b0;
        nwords  = (n + 3) / 4;
        for (int w = 0; w < nwords; w++) begin
            x.adr = 6'((int'(base) + w) % 64);
            x.dat = 32'h0;
            x.sel = 4'h0;
            x.we  = !verify;
            lane_mask = 32'h0;
            for (int k = 0; k < 4; k++) begin
                if (4 * w + k < n) begin
                    x.dat     = x.dat | ({24'h0, img[4 * w + k]} << (8 * k));
                    x.sel     = x.sel | (4'h1 << k);
                    lane_mask = lane_mask | (32'hFF << (8 * k));
                end
            end
            if (verify && (((mem[x.adr] ^ x.dat) & lane_mask) != 32'h0)) exp_err = 1'b1;
            exp_q.push_back(x);
        end
    endtask

    task automatic pulse_start(input logic [5:0] base, input bit verify);
        @(negedge clk);
        bus.i_start    = 1'b1;
        bus.i_base_adr = base;
        bus.i_verify   = verify;
        @(negedge clk);
        bus.i_start = 1'b0;
        check("busy_after_start", bus.o_busy, 1'b1);
        check("err_cleared_on_start", bus.o_err, 1'b0);
        check("words_cleared_on_start", bus.o_words, 0);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit last, input int gap);
        int t;
        bus.i_valid = 1'b1;
        bus.i_data  = b;
        bus.i_last  = last;
        t = 0;
        while (!bus.o_ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) check("ready_timeout", bus.o_ready, 1'b1);
        @(negedge clk);
        bus.i_valid = 1'b0;
        bus.i_last  = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic run_image(input logic [5:0] base, input bit verify, input int n,
                             input int delay, input int gap);
        bit exp_err;
        int nwords;
        int t;
        ack_delay = delay;
        build_expect(base, verify, n, exp_err, nwords);
        pulse_start(base, verify);
        for (int i = 0; i < n; i++) send_byte(img[i], i == n - 1, gap);
        t = 0;
        while (!bus.o_done && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("done_seen", bus.o_done, 1'b1);
        check("words_at_done", bus.o_words, nwords % 128);
        check("err_at_done", bus.o_err, exp_err);
        check("transfers_drained", exp_q.size(), 0);
        @(negedge clk);
        check("done_one_cycle", bus.o_done, 1'b0);
        check("idle_not_busy", bus.o_busy, 1'b0);
        check("idle_not_ready", bus.o_ready, 1'b0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        rst            = 1'b1;
        bus.i_start    = 1'b0;
        bus.i_verify   = 1'b0;
        bus.i_base_adr = '0;
        bus.i_data     = '0;
        bus.i_valid    = 1'b0;
        bus.i_last     = 1'b0;
        bus.i_wb_rdt   = '0;
        bus.i_wb_ack   = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_ready", bus.o_ready, 1'b0);
        check("rst_busy",  bus.o_busy,  1'b0);
        check("rst_done",  bus.o_done,  1'b0);
        check("rst_err",   bus.o_err,   1'b0);
        check("rst_words", bus.o_words, 0);
        check("rst_stb",   bus.o_wb_stb, 1'b0);
        check("rst_we",    bus.o_wb_we,  1'b0);
        check("rst_sel",   bus.o_wb_sel, 0);
        check("rst_adr",   bus.o_wb_adr, 0);
        check("rst_dat",   bus.o_wb_dat, 0);
        rst = 1'b0;
        @(negedge clk);

        // Full word write
        img[0] = 8'h11; img[1] = 8'h22; img[2] = 8'h33; img[3] = 8'h44;
        run_image(6'h10, 1'b0, 4, 1, 0);
        check("lit_write_word", mem[6'h10], 32'h44332211);
        check("lit_write_words", bus.o_words, 1);

        // Partial word write
        img[0] = 8'hAA; img[1] = 8'hBB; img[2] = 8'hCC;
        run_image(6'h05, 1'b0, 3, 1, 0);
        check("lit_partial_word", mem[6'h05], 32'h00CCBBAA);
        check("lit_partial_err", bus.o_err, 1'b0);

        // Verify mismatch, then match
        mem[6'h20] = 32'h04FF0201;
        img[0] = 8'h01; img[1] = 8'h02; img[2] = 8'h03; img[3] = 8'h04;
        run_image(6'h20, 1'b1, 4, 1, 0);
        check("lit_verify_err_sticky", bus.o_err, 1'b1);
        mem[6'h20] = 32'h04030201;
        run_image(6'h20, 1'b1, 4, 1, 0);
        check("lit_verify_ok", bus.o_err, 1'b0);

        // Partial verify: differing unmasked lane is ignored
        mem[6'h21] = 32'hEE030201;
        run_image(6'h21, 1'b1, 3, 0, 0);
        check("lit_verify_unmasked_lane", bus.o_err, 1'b0);
        check("lit_verify_no_write", mem[6'h21], 32'hEE030201);

        // Ack stall of 7 cycles plus stream stalls
        img[0] = 8'h5A; img[1] = 8'hA5; img[2] = 8'h0F; img[3] = 8'hF0;
        run_image(6'h30, 1'b0, 4, 7, 2);
        check("lit_stall_word", mem[6'h30], 32'hF00FA55A);
        check("lit_stall_words", bus.o_words, 1);

        // Address wrap
        for (int i = 0; i < 8; i++) img[i] = 8'(8'h80 + i);
        run_image(6'h3F, 1'b0, 8, 2, 0);
        check("lit_wrap_first", mem[6'h3F], 32'h83828180);
        check("lit_wrap_second", mem[6'h00], 32'h87868584);
        check("lit_wrap_words", bus.o_words, 2);

        // Stray acks in FILL, then reset while strobing
        mon_en = 1'b0;
        pulse_start(6'h08, 1'b0);
        bus.i_wb_ack = 1'b1;
        send_byte(8'h01, 1'b0, 0);
        send_byte(8'h02, 1'b0, 0);
        send_byte(8'h03, 1'b0, 0);
        bus.i_wb_ack = 1'b0;
        send_byte(8'h04, 1'b0, 0);
        t = 0;
        while (!bus.o_wb_stb && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("stray_ack_stb", bus.o_wb_stb, 1'b1);
        check("stray_ack_adr", bus.o_wb_adr, 6'h08);
        check("stray_ack_words", bus.o_words, 0);
        check("stray_ack_dat", bus.o_wb_dat, 32'h04030201);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_stb", bus.o_wb_stb, 1'b0);
        check("async_rst_sel", bus.o_wb_sel, 0);
        check("async_rst_we",  bus.o_wb_we,  1'b0);
        check("async_rst_busy", bus.o_busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_busy",  bus.o_busy, 1'b0);
        check("post_rst_ready", bus.o_ready, 1'b0);
        check("post_rst_stb",   bus.o_wb_stb, 1'b0);
        exp_q.delete();
        mon_en = 1'b1;

        // Normal run after reset
        img[0] = 8'hDE; img[1] = 8'hAD; img[2] = 8'hBE; img[3] = 8'hEF;
        run_image(6'h02, 1'b0, 4, 1, 0);
        check("lit_after_rst_word", mem[6'h02], 32'hEFBEADDE);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/servile_wb_byte_loader.md
Name: servile_wb_byte_loader

Overview:
Wishbone initiator that turns a byte stream (UART/SPI boot path) into 32-bit Wishbone accesses on the shared-SRAM data port of the servile memory arbiter. Write mode packs 4 bytes per word and writes consecutive words starting at a programmed base. Verify mode reads the same words back and compares them against the stream. It sits between the boot-stream source and the arbiter's Wishbone slave port, and runs while the core is held in reset.

Parameters:
aw, 8, byte address width of shared SRAM (Wishbone word address is aw-2 bits)

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, asynchronous, active-high
i_start  in  1  start pulse, sampled only in IDLE
i_verify  in  1  latched at start: 0 = write, 1 = read-and-compare
i_base_adr  in  aw-2  first word address, latched at start
i_data  in  8  stream byte
i_valid  in  1  stream byte valid
i_last  in  1  qualifies i_data as final byte of the image
o_ready  out  1  byte accepted when i_valid & o_ready
o_busy  out  1  high in any state except IDLE
o_done  out  1  one-cycle pulse on completion
o_err  out  1  sticky verify mismatch, cleared on i_start
o_words  out  aw-1  words completed since start
o_wb_adr  out  aw-2  word address
o_wb_dat  out  32  write data
o_wb_sel  out  4  byte enables
o_wb_we  out  1  write enable
o_wb_stb  out  1  strobe (also serves as cyc)
i_wb_rdt  in  32  read data
i_wb_ack  in  1  acknowledge

Behaviour:
- Reset (async, any state): state=IDLE, lane index 0, word/mask 0, o_ready=0, o_wb_stb=0, o_wb_we=0, o_wb_sel=0, o_wb_adr=0, o_wb_dat=0, o_done=0, o_err=0, o_words=0. o_wb_stb falls immediately, even mid-transaction.
- States: IDLE, FILL, BUS, DONE.
- IDLE:
  - o_ready=0.
  - On i_start: latch i_base_adr and i_verify; clear o_err, o_words, lane, word and mask; go to FILL next cycle.
- FILL:
  - o_ready=1, o_wb_stb=0.
  - Byte accept: write byte into lane (lane 0 = bits 7:0, little-endian), set mask bit lane, lane++.
  - Go to BUS on the cycle after the accept if lane was 3 or i_last=1. Latch the last flag.
- BUS:
  - o_ready=0, o_wb_stb=1, o_wb_we=!verify, o_wb_dat=word, o_wb_sel=mask.
  - All Wishbone outputs are held stable until i_wb_ack; ack latency is unbounded (arbiter stalls during RF writes).
  - On ack:
    - In verify mode, compare only the masked byte lanes of i_wb_rdt against word; any difference sets o_err.
    - Word address += 1, modulo 2^(aw-2). o_words += 1, wrapping.
    - Clear lane, word and mask.
    - Go to DONE if last, else FILL.
  - o_wb_stb is low the cycle after ack; no back-to-back strobe.
- DONE: o_done=1 for exactly one cycle, then IDLE.
- Boundaries:
  - i_start outside IDLE is ignored.
  - i_wb_ack outside BUS is ignored.
  - i_last with lane<3 issues a partial word (mask 4'b0001/0011/0111).
  - Verify mode still drives sel=mask; the mismatch check ignores unmasked lanes.
  - Stream stalls (i_valid low) in FILL hold state indefinitely.
- Latency: last byte of a word accepted at cycle N → o_wb_stb high at N+1. Ack at cycle M → o_ready high at M+1, or o_done at M+1.

Decomposition:
- Shared package: state encoding constants (IDLE/FILL/BUS/DONE) and lane-width constant (4 lanes × 8 bits).
- One natural sub-module: servile_byte_packer. It holds lane index, word and mask, with clear and accept inputs and a full/last output.
- FSM and Wishbone drive stay in the top.

Test Plan:
- Write, base 0x10, bytes 11,22,33,44 (last on 44), ack after 1 cycle → one write: adr=0x10, dat=0x44332211, sel=4'hF, we=1; then o_done pulse, o_words=1.
- Partial: bytes AA,BB,CC (last on CC), base 0x05 → adr=0x05, dat[23:0]=0xCCBBAA, sel=4'b0111; o_err=0.
- Verify mismatch:
  - Setup: i_verify=1, stream 01,02,03,04; responder returns 0x04FF0201.
  - Required: we=0, sel=4'hF, o_err=1 after ack, o_done pulses.
  - Rerun with rdt=0x04030201: o_err=0.
- Stall: hold i_wb_ack low 7 cycles → adr/dat/sel/stb stable all 7 cycles; o_ready=0 throughout; single o_words increment.
- Wrap: base 0x3F (aw=8), 8 bytes, last on 8th → writes at adr 0x3F then 0x00; o_words=2.
- Reset mid-BUS: assert i_rst while stb=1 → stb, sel, we fall the same cycle (async); after release state is IDLE, o_busy=0; a new i_start runs normally.
